// File: rtl/conv_encoder_if.sv
// Bit-serial stream into the K=7 convolutional encoder and the coded X/Y pair stream out of it.
interface conv_encoder_if;
   logic in_bits;
   logic in_valid;
   logic in_last;
   logic in_ready;
   logic out_x;
   logic out_y;
   logic out_valid;
   logic out_last;
   logic ovf;

   modport master (
      output in_bits, in_valid, in_last,
      input  in_ready, out_x, out_y, out_valid, out_last, ovf
   );

   modport slave (
      input  in_bits, in_valid, in_last,
      output in_ready, out_x, out_y, out_valid, out_last, ovf
   );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 bit-serial convolutional encoder; CONV_ENC_TAIL_EN adds zero-tail burst termination.
// Latency: one cycle from an accepted bit (or generated tail bit) to its registered X/Y pair.
// Backpressure: none downstream; in_ready drops only during the tail, where arriving bits are dropped and flagged on ovf.
module conv_encoder #(
   parameter int           K  = 7,
   parameter logic [K-1:0] G1 = 7'o171,
   parameter logic [K-1:0] G2 = 7'o133
) (
   input  logic          clk,
   input  logic          reset,
   conv_encoder_if.slave bus
);
   logic [K-2:0] sr, sr_nxt;
   logic [K-1:0] taps;
   logic         accept, shift, bit_in, last_pair, ovf_nxt;

`ifdef CONV_ENC_TAIL_EN
   localparam int CW = $clog2(K - 1);
   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
   state_t        state, state_nxt;
   logic [CW-1:0] tail_cnt, tail_cnt_nxt;
   assign bus.in_ready = (state != TAIL);
`else
   assign bus.in_ready = 1'b1;
`endif
   assign accept = bus.in_valid & bus.in_ready;

   always_comb begin
      sr_nxt    = sr;
      shift     = 1'b0;
      bit_in    = bus.in_bits;
      last_pair = 1'b0;
      ovf_nxt   = 1'b0;
`ifdef CONV_ENC_TAIL_EN
      state_nxt    = state;
      tail_cnt_nxt = tail_cnt;
      if (state == TAIL) begin
         // Flush K-1 zeros back-to-back so the trellis ends in state 0.
         shift   = 1'b1;
         bit_in  = 1'b0;
         ovf_nxt = bus.in_valid;
         if (tail_cnt == CW'(K - 2)) begin
            last_pair    = 1'b1;
            state_nxt    = IDLE;
            tail_cnt_nxt = '0;
         end else begin
            tail_cnt_nxt = tail_cnt + CW'(1);
         end
      end else if (accept) begin
         shift     = 1'b1;
         state_nxt = bus.in_last ? TAIL : DATA;
      end
`else
      if (accept) begin
         shift     = 1'b1;
         last_pair = bus.in_last;
      end
`endif
      if (shift) sr_nxt = {sr[K-3:0], bit_in};
`ifndef CONV_ENC_TAIL_EN
      // Without a tail, restart the trellis from state 0 for the next burst.
      if (last_pair) sr_nxt = '0;
`endif
   end

   // Tap vector runs newest-first: current bit, then sr[0] .. sr[K-2].
   always_comb begin
      taps[K-1] = bit_in;
      for (int i = 0; i < K - 1; i++) taps[K-2-i] = sr[i];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
`ifdef CONV_ENC_TAIL_EN
         state    <= IDLE;
         tail_cnt <= '0;
`endif
         sr            <= '0;
         bus.out_valid <= 1'b0;
         bus.out_x     <= 1'b0;
         bus.out_y     <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.ovf       <= 1'b0;
      end else begin
`ifdef CONV_ENC_TAIL_EN
         state    <= state_nxt;
         tail_cnt <= tail_cnt_nxt;
`endif
         sr            <= sr_nxt;
         bus.out_valid <= shift;
         bus.out_x     <= shift & (^(taps & G1));
         bus.out_y     <= shift & (^(taps & G2));
         bus.out_last  <= last_pair;
         bus.ovf       <= ovf_nxt;
      end
   end
endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed and random bursts against a convolution-sum reference model.
module tb_conv_encoder;
   logic clk   = 1'b0;
   logic reset = 1'b0;

   conv_encoder_if bus ();

   conv_encoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] g1 = 7'o171;
   logic [6:0] g2 = 7'o133;
   bit         hist[$];
   int         tail_left = 0;
   int         checks    = 0;
   int         failures  = 0;
   int         cyc       = 0;
   logic       exp_valid, exp_x, exp_y, exp_last, exp_ovf, exp_ready, obs_ready;

   // Drive one cycle and predict the pair that follows it. Coded bits are the
   // mod-2 convolution of the burst's bit history with the generator taps.
   task automatic step(input logic rst, input logic v, input logic b, input logic l);
      obs_ready    = bus.in_ready;
      bus.in_valid = v;
      bus.in_bits  = b;
      bus.in_last  = l;
      reset        = rst;
`ifdef CONV_ENC_TAIL_EN
      exp_ready = (tail_left == 0);
`else
      exp_ready = 1'b1;
`endif
      exp_valid = 1'b0;
      exp_x     = 1'b0;
      exp_y     = 1'b0;
      exp_last  = 1'b0;
      exp_ovf   = 1'b0;
      if (!rst) begin
         hist.delete();
         tail_left = 0;
      end else if (tail_left > 0) begin
         exp_ovf   = v;
         exp_valid = 1'b1;
         hist.push_back(1'b0);
         tail_left--;
         exp_last = (tail_left == 0);
      end else if (v) begin
         exp_valid = 1'b1;
         hist.push_back(b);
         if (l) begin
`ifdef CONV_ENC_TAIL_EN
            tail_left = 6;
`else
            exp_last = 1'b1;
`endif
         end
      end
      if (exp_valid) begin
         for (int d = 0; d < 7; d++) begin
            if (d < hist.size()) begin
               exp_x ^= g1[6-d] & hist[hist.size()-1-d];
               exp_y ^= g2[6-d] & hist[hist.size()-1-d];
            end
         end
      end
      if (exp_last) hist.delete();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.ovf, bus.in_ready} !== 6'b000001) begin
         failures++;
         $display("FAIL reset_state got vld/x/y/last/ovf/rdy=%b%b%b%b%b%b need 000001",
                  bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.ovf, bus.in_ready);
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
         checks++;
         if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.ovf, bus.in_ready} !== 6'b000001) begin
            failures++;
            $display("FAIL idle cyc=%0d got vld/x/y/last/ovf/rdy=%b%b%b%b%b%b need 000001", cyc,
                     bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.ovf, bus.in_ready);
         end
      end
   endtask

   task automatic test_impulse();
      bit         px[$], py[$];
      int         last_at, nrdy0;
      logic [6:0] gx, gy;
      last_at = -1;
      nrdy0   = 0;
      for (int i = 0; i < 9; i++) begin
         if (i == 0) step(1'b1, 1'b1, 1'b1, 1'b1);
         else        step(1'b1, 1'b0, 1'($urandom), 1'b0);
         checks++;
         if ({bus.out_valid, bus.out_last, bus.ovf, obs_ready} !== {exp_valid, exp_last, exp_ovf, exp_ready} ||
             (exp_valid && {bus.out_x, bus.out_y} !== {exp_x, exp_y})) begin
            failures++;
            $display("FAIL impulse cyc=%0d got vld/last/ovf/rdy/x/y=%b%b%b%b%b%b need %b%b%b%b%b%b", cyc,
                     bus.out_valid, bus.out_last, bus.ovf, obs_ready, bus.out_x, bus.out_y,
                     exp_valid, exp_last, exp_ovf, exp_ready, exp_x, exp_y);
         end
         if (obs_ready === 1'b0) nrdy0++;
         if (bus.out_valid === 1'b1) begin
            px.push_back(bus.out_x);
            py.push_back(bus.out_y);
            if (bus.out_last === 1'b1) last_at = px.size();
         end
      end
      gx = '0;
      gy = '0;
      for (int i = 0; i < px.size() && i < 7; i++) begin
         gx[6-i] = px[i];
         gy[6-i] = py[i];
      end
      checks++;
`ifdef CONV_ENC_TAIL_EN
      if (px.size() != 7 || gx !== 7'b1111001 || gy !== 7'b1011011 || last_at != 7 || nrdy0 != 6) begin
         failures++;
         $display("FAIL impulse_vectors got n=%0d x=%b y=%b last_at=%0d rdy_low=%0d need n=7 x=1111001 y=1011011 last_at=7 rdy_low=6",
                  px.size(), gx, gy, last_at, nrdy0);
      end
`else
      if (px.size() != 1 || gx !== 7'b1000000 || gy !== 7'b1000000 || last_at != 1 || nrdy0 != 0) begin
         failures++;
         $display("FAIL impulse_vectors got n=%0d x=%b y=%b last_at=%0d rdy_low=%0d need n=1 x=1000000 y=1000000 last_at=1 rdy_low=0",
                  px.size(), gx, gy, last_at, nrdy0);
      end
`endif
   endtask

   task automatic test_all_ones();
      bit px[$], py[$];
      int last_at;
      bit ok;
      last_at = -1;
      for (int i = 0; i < 26; i++) begin
         if (i < 16) step(1'b1, 1'b1, 1'b1, (i == 15) ? 1'b1 : 1'b0);
         else        step(1'b1, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({bus.out_valid, bus.out_last, bus.ovf, obs_ready} !== {exp_valid, exp_last, exp_ovf, exp_ready} ||
             (exp_valid && {bus.out_x, bus.out_y} !== {exp_x, exp_y})) begin
            failures++;
            $display("FAIL all_ones cyc=%0d got vld/last/ovf/rdy/x/y=%b%b%b%b%b%b need %b%b%b%b%b%b", cyc,
                     bus.out_valid, bus.out_last, bus.ovf, obs_ready, bus.out_x, bus.out_y,
                     exp_valid, exp_last, exp_ovf, exp_ready, exp_x, exp_y);
         end
         if (bus.out_valid === 1'b1) begin
            px.push_back(bus.out_x);
            py.push_back(bus.out_y);
            if (bus.out_last === 1'b1) last_at = px.size();
         end
      end
      ok = (px.size() >= 16) && ({px[0], py[0]} == 2'b11) && ({px[1], py[1]} == 2'b01);
      for (int i = 6; i < 16 && i < px.size(); i++) ok = ok && ({px[i], py[i]} == 2'b11);
      checks++;
`ifdef CONV_ENC_TAIL_EN
      if (!ok || px.size() != 22 || last_at != 22) begin
         failures++;
         $display("FAIL all_ones_vectors got pattern_ok=%0d n=%0d last_at=%0d need pattern_ok=1 n=22 last_at=22",
                  ok, px.size(), last_at);
      end
`else
      if (!ok || px.size() != 16 || last_at != 16) begin
         failures++;
         $display("FAIL all_ones_vectors got pattern_ok=%0d n=%0d last_at=%0d need pattern_ok=1 n=16 last_at=16",
                  ok, px.size(), last_at);
      end
`endif
   endtask

   task automatic test_gapped();
      logic [4:0] vp;
      logic [2:0] dat;
      int         k;
      vp  = 5'b10101;
      dat = 3'b101;
      k   = 0;
      for (int i = 0; i < 14; i++) begin
         if (i < 5 && vp[i]) begin
            step(1'b1, 1'b1, dat[k], (k == 2) ? 1'b1 : 1'b0);
            k++;
         end else begin
            step(1'b1, 1'b0, 1'($urandom), 1'($urandom));
         end
         checks++;
         if ({bus.out_valid, bus.out_last, bus.ovf, obs_ready} !== {exp_valid, exp_last, exp_ovf, exp_ready} ||
             (exp_valid && {bus.out_x, bus.out_y} !== {exp_x, exp_y})) begin
            failures++;
            $display("FAIL gapped cyc=%0d got vld/last/ovf/rdy/x/y=%b%b%b%b%b%b need %b%b%b%b%b%b", cyc,
                     bus.out_valid, bus.out_last, bus.ovf, obs_ready, bus.out_x, bus.out_y,
                     exp_valid, exp_last, exp_ovf, exp_ready, exp_x, exp_y);
         end
      end
   endtask

   task automatic test_ovf();
      int   len, offend, seen;
      logic v;
      len    = int'($urandom_range(3, 8));
      offend = 0;
      seen   = 0;
      for (int i = 0; i < len + 12; i++) begin
         if (i < len) begin
            step(1'b1, 1'b1, 1'($urandom), (i == len - 1) ? 1'b1 : 1'b0);
         end else if (i < len + 6) begin
            v = (i == len || i == len + 3) ? 1'b1 : 1'($urandom);
`ifdef CONV_ENC_TAIL_EN
            if (v) offend++;
`endif
            step(1'b1, v, 1'($urandom), 1'($urandom));
            if (bus.ovf === 1'b1) seen++;
         end else begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
         end
         checks++;
         if ({bus.out_valid, bus.out_last, bus.ovf, obs_ready} !== {exp_valid, exp_last, exp_ovf, exp_ready} ||
             (exp_valid && {bus.out_x, bus.out_y} !== {exp_x, exp_y})) begin
            failures++;
            $display("FAIL ovf cyc=%0d got vld/last/ovf/rdy/x/y=%b%b%b%b%b%b need %b%b%b%b%b%b", cyc,
                     bus.out_valid, bus.out_last, bus.ovf, obs_ready, bus.out_x, bus.out_y,
                     exp_valid, exp_last, exp_ovf, exp_ready, exp_x, exp_y);
         end
      end
      checks++;
      if (seen != offend) begin
         failures++;
         $display("FAIL ovf_count got %0d pulses need %0d", seen, offend);
      end
   endtask

   task automatic test_tail_reset();
      for (int i = 0; i < 5; i++) begin
         if (i < 3) step(1'b1, 1'b1, (i == 1) ? 1'b0 : 1'b1, (i == 2) ? 1'b1 : 1'b0);
         else       step(1'b1, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({bus.out_valid, bus.out_last, bus.ovf, obs_ready} !== {exp_valid, exp_last, exp_ovf, exp_ready} ||
             (exp_valid && {bus.out_x, bus.out_y} !== {exp_x, exp_y})) begin
            failures++;
            $display("FAIL tail_reset cyc=%0d got vld/last/ovf/rdy/x/y=%b%b%b%b%b%b need %b%b%b%b%b%b", cyc,
                     bus.out_valid, bus.out_last, bus.ovf, obs_ready, bus.out_x, bus.out_y,
                     exp_valid, exp_last, exp_ovf, exp_ready, exp_x, exp_y);
         end
      end
      // Reset lands on the third tail cycle.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.ovf, bus.in_ready} !== 6'b000001) begin
         failures++;
         $display("FAIL tail_reset_state got vld/x/y/last/ovf/rdy=%b%b%b%b%b%b need 000001",
                  bus.out_valid, bus.out_x, bus.out_y, bus.out_last, bus.ovf, bus.in_ready);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      test_impulse();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 170; i++) begin
         if (i < 160) step(1'b1, ($urandom % 4) != 0, 1'($urandom), ($urandom % 8) == 0);
         else         step(1'b1, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({bus.out_valid, bus.out_last, bus.ovf, obs_ready} !== {exp_valid, exp_last, exp_ovf, exp_ready} ||
             (exp_valid && {bus.out_x, bus.out_y} !== {exp_x, exp_y})) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got vld/last/ovf/rdy/x/y=%b%b%b%b%b%b need %b%b%b%b%b%b", cyc,
                     bus.out_valid, bus.out_last, bus.ovf, obs_ready, bus.out_x, bus.out_y,
                     exp_valid, exp_last, exp_ovf, exp_ready, exp_x, exp_y);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_bits  = 1'b0;
      bus.in_last  = 1'b0;
      test_reset();
      test_impulse();
      test_all_ones();
      test_gapped();
      test_ovf();
      test_tail_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
